pipe_stage_reg: RTL and testbench

Parametrised successor to the per-stage predPC/field registers of the Y86 pipeline. Holds one pipeline stage's payload (data, status, valid) and applies stall and bubble control. Adds valid/status tracking, stall/bubble conflict detection and a stall-watchdog FSM that flags a hung pipeline. Instantiated once per stage boundary (F, D, E, M, W), with widths set per stage.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_stall_wdog.sv | 78 +++++++
 rtl/pipe_stage_reg.sv | 134 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared Y86 pipeline constants and the stall-watchdog state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int PIPE_STAT_W = 3;

    // Y86 status encodings
    localparam logic [PIPE_STAT_W-1:0] SAOK = 3'd1;
    localparam logic [PIPE_STAT_W-1:0] SADR = 3'd2;
    localparam logic [PIPE_STAT_W-1:0] SINS = 3'd3;
    localparam logic [PIPE_STAT_W-1:0] SHLT = 3'd4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HUNG = 2'd2
    } wdog_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_stall_wdog.sv
// ============================================================================
// Module      : pipe_stall_wdog
// Description : Stall watchdog; flags a stage stalled for STALL_LIMIT+ cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_wdog
    import pipe_pkg::*;
#(
    parameter int STALL_LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stall_i,
    output logic hung_o
);

    localparam logic [15:0] c_limit = 16'(STALL_LIMIT);

    wdog_state_e state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] w_hold_inc;

    assign w_hold_inc = hold_q + 16'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            hold_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            RUN: begin
                if (stall_i) begin
                    state_d = HOLD;
                    hold_d  = 16'd1;
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    state_d = RUN;
                    hold_d  = 16'd0;
                end else begin
                    hold_d = w_hold_inc;
                    if (w_hold_inc == c_limit) begin
                        state_d = HUNG;
                    end
                end
            end
            HUNG: begin
                // Count parks at the limit while the stall persists
                if (!stall_i) begin
                    state_d = RUN;
                    hold_d  = 16'd0;
                end
            end
            default: begin
                state_d = RUN;
                hold_d  = 16'd0;
            end
        endcase
    end

    always_comb begin
        hung_o = (state_q == HUNG);
    end

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : One pipeline stage register with stall/bubble control, sticky
//               conflict flag, stall watchdog and optional perf counters
//               (enabled by defining PIPE_STAGE_REG_PERF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W      = 64,
    parameter logic [DATA_W-1:0]  RESET_VAL   = '0,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL  = '0,
    parameter int                 STAT_W      = PIPE_STAT_W,
    parameter logic [STAT_W-1:0]  STAT_BUBBLE = STAT_W'(SAOK),
    parameter int                 STALL_LIMIT = 16,
    parameter int                 CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic              clr_err_i,
    input  logic              valid_i,
    input  logic [STAT_W-1:0] stat_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [STAT_W-1:0] stat_o,
    output logic [DATA_W-1:0] data_o,
    output logic              conflict_o,
    output logic              hung_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              valid_q, valid_d;
    logic [STAT_W-1:0] stat_q, stat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              conflict_q, conflict_d;

    // Stall outranks bubble; a simultaneous request is recorded as a conflict
    always_comb begin
        valid_d = valid_q;
        stat_d  = stat_q;
        data_d  = data_q;
        if (stall_i) begin
            valid_d = valid_q;
        end else if (bubble_i) begin
            valid_d = 1'b0;
            stat_d  = STAT_BUBBLE;
            data_d  = BUBBLE_VAL;
        end else begin
            valid_d = valid_i;
            stat_d  = stat_i;
            data_d  = data_i;
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (stall_i && bubble_i) begin
            conflict_d = 1'b1;
        end else if (clr_err_i) begin
            conflict_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            stat_q     <= STAT_BUBBLE;
            data_q     <= RESET_VAL;
            conflict_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            stat_q     <= stat_d;
            data_q     <= data_d;
            conflict_q <= conflict_d;
        end
    end

    assign valid_o    = valid_q;
    assign stat_o     = stat_q;
    assign data_o     = data_q;
    assign conflict_o = conflict_q;

    pipe_stall_wdog #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_wdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_i (stall_i),
        .hung_o  (hung_o)
    );

`ifdef PIPE_STAGE_REG_PERF_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_i && (stall_cnt_q != c_cnt_max)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (bubble_i && !stall_i && (bubble_cnt_q != c_cnt_max)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Scoreboard bench for pipe_stage_reg (directed plan + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int               DATA_W      = 64;
    localparam logic [63:0]      RESET_VAL   = 64'h0;
    localparam logic [63:0]      BUBBLE_VAL  = 64'h0;
    localparam int               STAT_W      = 3;
    localparam logic [2:0]       STAT_BUBBLE = 3'd1;
    localparam int               STALL_LIMIT = 4;
    localparam int               CNT_W       = 4;
    localparam int               CNT_MAX     = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              stall_i = 1'b0;
    logic              bubble_i = 1'b0;
    logic              clr_err_i = 1'b0;
    logic              valid_i = 1'b0;
    logic [STAT_W-1:0] stat_i = '0;
    logic [DATA_W-1:0] data_i = '0;
    logic              valid_o;
    logic [STAT_W-1:0] stat_o;
    logic [DATA_W-1:0] data_o;
    logic              conflict_o;
    logic              hung_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .RESET_VAL   (RESET_VAL),
        .BUBBLE_VAL  (BUBBLE_VAL),
        .STAT_W      (STAT_W),
        .STAT_BUBBLE (STAT_BUBBLE),
        .STALL_LIMIT (STALL_LIMIT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .bubble_i     (bubble_i),
        .clr_err_i    (clr_err_i),
        .valid_i      (valid_i),
        .stat_i       (stat_i),
        .data_i       (data_i),
        .valid_o      (valid_o),
        .stat_o       (stat_o),
        .data_o       (data_o),
        .conflict_o   (conflict_o),
        .hung_o       (hung_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  stat;
        logic [63:0] data;
        logic        conflict;
        logic        hung;
        int          scnt;
        int          bcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: architectural view of the stage
    logic        m_valid = 1'b0;
    logic [2:0]  m_stat  = 3'd1;
    logic [63:0] m_data  = 64'h0;
    logic        m_conf  = 1'b0;
    int          m_run   = 0;
    int          m_scnt  = 0;
    int          m_bcnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model's post-edge view goes to the scoreboard
    task automatic step(input logic rst, input logic stl, input logic bub, input logic clr,
                        input logic vld, input logic [2:0] st, input logic [63:0] d);
        exp_t e;
        @(negedge clk);
        rst_i = rst; stall_i = stl; bubble_i = bub; clr_err_i = clr;
        valid_i = vld; stat_i = st; data_i = d;
        if (rst) begin
            m_valid = 1'b0; m_stat = STAT_BUBBLE; m_data = RESET_VAL;
            m_conf = 1'b0; m_run = 0; m_scnt = 0; m_bcnt = 0;
        end else begin
            if (stl && bub)      m_conf = 1'b1;
            else if (clr)        m_conf = 1'b0;
            m_run = stl ? m_run + 1 : 0;
            if (stl) begin
                if (m_scnt < CNT_MAX) m_scnt++;
            end else if (bub) begin
                m_valid = 1'b0; m_stat = STAT_BUBBLE; m_data = BUBBLE_VAL;
                if (m_bcnt < CNT_MAX) m_bcnt++;
            end else begin
                m_valid = vld; m_stat = st; m_data = d;
            end
        end
        e.valid = m_valid; e.stat = m_stat; e.data = m_data;
        e.conflict = m_conf; e.hung = (m_run >= STALL_LIMIT);
`ifdef PIPE_STAGE_REG_PERF_EN
        e.scnt = m_scnt; e.bcnt = m_bcnt;
`else
        e.scnt = 0; e.bcnt = 0;
`endif
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("valid_o",      64'(valid_o),      64'(e.valid));
            check("stat_o",       64'(stat_o),       64'(e.stat));
            check("data_o",       data_o,            e.data);
            check("conflict_o",   64'(conflict_o),   64'(e.conflict));
            check("hung_o",       64'(hung_o),       64'(e.hung));
            check("stall_cnt_o",  64'(stall_cnt_o),  64'(e.scnt));
            check("bubble_cnt_o", 64'(bubble_cnt_o), 64'(e.bcnt));
        end
    end

    initial begin
        int stall_left;
        int waited;
        // Reset then load
        step(1, 0, 0, 0, 0, 0, 64'h0);
        step(1, 0, 0, 0, 0, 0, 64'h0);
        step(0, 0, 0, 0, 1, 3'd1, 64'h1234);
        // Stall hold
        step(0, 0, 0, 0, 1, 3'd1, 64'hAA);
        repeat (3) step(0, 1, 0, 0, 1, 3'd2, 64'hBB);
        step(0, 0, 0, 0, 1, 3'd2, 64'hBB);
        // Bubble
        step(0, 0, 0, 0, 1, 3'd1, 64'hCC);
        step(0, 0, 1, 0, 1, 3'd4, 64'hEE);
        // Conflict, clear, and conflict with simultaneous clear
        step(0, 0, 0, 0, 1, 3'd3, 64'hDD);
        step(0, 1, 1, 0, 1, 3'd1, 64'h11);
        step(0, 0, 0, 0, 1, 3'd1, 64'h22);
        step(0, 0, 0, 1, 1, 3'd1, 64'h33);
        step(0, 1, 1, 1, 1, 3'd1, 64'h44);
        step(0, 0, 0, 1, 1, 3'd1, 64'h55);
        // Watchdog: short stall, long stall, reset while hung
        repeat (3) step(0, 1, 0, 0, 0, 3'd1, 64'h66);
        step(0, 0, 0, 0, 1, 3'd1, 64'h77);
        repeat (6) step(0, 1, 0, 0, 0, 3'd1, 64'h88);
        step(0, 0, 0, 0, 1, 3'd1, 64'h99);
        repeat (5) step(0, 1, 0, 0, 0, 3'd1, 64'hA0);
        step(1, 1, 0, 0, 0, 3'd1, 64'hA1);
        step(0, 0, 0, 0, 1, 3'd2, 64'hA2);
        // Counter saturation
        repeat (20) step(0, 1, 0, 0, 0, 3'd1, 64'hB0);
        repeat (20) step(0, 0, 1, 0, 0, 3'd1, 64'hB1);
        step(0, 0, 0, 0, 1, 3'd1, 64'hB2);
        // Random traffic with bursty stalls
        stall_left = 0;
        for (int i = 0; i < 400; i++) begin
            logic r, s, b, c;
            r = ($urandom_range(0, 59) == 0);
            if (stall_left == 0 && $urandom_range(0, 4) == 0)
                stall_left = $urandom_range(1, 8);
            s = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            b = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 7) == 0);
            step(r, s, b, c, 1'($urandom), 3'($urandom), {$urandom, $urandom});
        end
        step(0, 0, 0, 0, 0, 3'd0, 64'h0);
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
